univ_shift_reg_n: RTL and testbench

//   Parametrised universal shift register: hold, shift-up, shift-down and parallel load

---
 rtl/univ_shift_reg_n.sv | 111 +++++++++++
 tb/tb_univ_shift_reg_n.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Universal WIDTH-bit shift register (hold / shift-up / shift-down / load) with an
// autonomous burst sequencer. Define SHREG_ROTATE_EN to add the ROT rotate-select port.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             SR_SER,
    input  logic             SL_SER,
    input  logic             EN,
    input  logic             START,
    input  logic [CNT_W-1:0] AMT,
`ifdef SHREG_ROTATE_EN
    input  logic             ROT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             SO_UP,
    output logic             SO_DN,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic             dir_dn_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;

    logic             fill_up;
    logic             fill_dn;
    logic [WIDTH-1:0] up_d;
    logic [WIDTH-1:0] dn_d;
    logic             start_ok;

`ifdef SHREG_ROTATE_EN
    assign fill_up = ROT ? q_q[WIDTH-1] : SR_SER;
    assign fill_dn = ROT ? q_q[0]       : SL_SER;
`else
    assign fill_up = SR_SER;
    assign fill_dn = SL_SER;
`endif

    assign up_d = {q_q[WIDTH-2:0], fill_up};
    assign dn_d = {fill_dn, q_q[WIDTH-1:1]};

    // A burst needs a non-zero count and a shifting mode; otherwise START falls through to EN/S.
    assign start_ok = START && (AMT != '0) && ((S == MODE_UP) || (S == MODE_DN));

    // NOTE: all state below is registered with non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= IDLE;
            q_q      <= '0;
            dir_dn_q <= 1'b0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (start_ok) begin
                dir_dn_q <= (S == MODE_DN);
                q_q      <= (S == MODE_DN) ? dn_d : up_d;
                rem_q    <= AMT - CNT_W'(1);
                if (AMT == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end else begin
                    state_q <= BURST;
                    busy_q  <= 1'b1;
                end
            end else if (EN) begin
                case (S)
                    MODE_UP:   q_q <= up_d;
                    MODE_DN:   q_q <= dn_d;
                    MODE_LOAD: q_q <= D;
                    MODE_HOLD: q_q <= q_q;
                    default:   q_q <= q_q;
                endcase
            end
        end else begin
            q_q   <= dir_dn_q ? dn_d : up_d;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

    assign Q     = q_q;
    assign SO_UP = q_q[WIDTH-1];
    assign SO_DN = q_q[0];
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Self-checking bench for univ_shift_reg_n: directed scenarios plus randomized traffic,
// compared each cycle against a count-based behavioural model.
module tb_univ_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             CLK;
    logic             CLR;
    logic [1:0]       S;
    logic [WIDTH-1:0] D;
    logic             SR_SER;
    logic             SL_SER;
    logic             EN;
    logic             START;
    logic [CNT_W-1:0] AMT;
    logic             ROT;
    logic [WIDTH-1:0] Q;
    logic             SO_UP;
    logic             SO_DN;
    logic             BUSY;
    logic             DONE;

    int checks   = 0;
    int failures = 0;

    // Reference model: register value as an integer and the number of burst shifts still owed.
    int m_q    = 0;
    int m_left = 0;
    bit m_dn   = 0;
    bit m_done = 0;

    univ_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .S      (S),
        .D      (D),
        .SR_SER (SR_SER),
        .SL_SER (SL_SER),
        .EN     (EN),
        .START  (START),
        .AMT    (AMT),
`ifdef SHREG_ROTATE_EN
        .ROT    (ROT),
`endif
        .Q      (Q),
        .SO_UP  (SO_UP),
        .SO_DN  (SO_DN),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int shifted(input int q, input bit dn);
        bit rot_on;
        int ser;
`ifdef SHREG_ROTATE_EN
        rot_on = ROT;
`else
        rot_on = 1'b0;
`endif
        if (dn) begin
            ser = rot_on ? (q % 2) : int'(SL_SER);
            return q / 2 + ser * (MOD / 2);
        end
        ser = rot_on ? int'(q >= MOD / 2) : int'(SR_SER);
        return (q * 2) % MOD + ser;
    endfunction

    // Advance the model by one edge using the inputs that the DUT will sample on that edge.
    task automatic model_edge();
        if (CLR) begin
            m_q = 0; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_q = shifted(m_q, m_dn);
            m_left--;
            m_done = (m_left == 0);
        end else if (START && AMT != 0 && (S == 2'b01 || S == 2'b10)) begin
            m_dn   = (S == 2'b10);
            m_q    = shifted(m_q, m_dn);
            m_left = int'(AMT) - 1;
            m_done = (m_left == 0);
        end else begin
            m_done = 0;
            if (EN) begin
                case (S)
                    2'b01:   m_q = shifted(m_q, 1'b0);
                    2'b10:   m_q = shifted(m_q, 1'b1);
                    2'b11:   m_q = int'(D);
                    default: m_q = m_q;
                endcase
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge CLK);
        #1;
        check({tag, ".q"},    32'(Q),     32'(m_q));
        check({tag, ".busy"}, 32'(BUSY),  32'(m_left > 0));
        check({tag, ".done"}, 32'(DONE),  32'(m_done));
        check({tag, ".soup"}, 32'(SO_UP), 32'(m_q >= MOD / 2));
        check({tag, ".sodn"}, 32'(SO_DN), 32'(m_q % 2));
    endtask

    task automatic idle_inputs();
        CLR = 0; S = 2'b00; D = '0; SR_SER = 0; SL_SER = 0;
        EN = 0; START = 0; AMT = '0; ROT = 0;
    endtask

    task automatic load(input logic [WIDTH-1:0] val, input string tag);
        S = 2'b11; D = val; EN = 1; START = 0;
        tick(tag);
        EN = 0; S = 2'b00;
    endtask

    initial begin
        idle_inputs();
        CLR = 1;
        tick("reset");
        CLR = 0;

        // 1. load then clear
        load(8'hA5, "t1_load");
        check("t1_const_a5", 32'(Q), 32'h0000_00A5);
        CLR = 1;
        tick("t1_clr");
        CLR = 0;
        check("t1_const_clr", 32'({Q, BUSY, DONE}), 32'h0);

        // 2. single steps and hold
        load(8'h81, "t2_load");
        S = 2'b01; SR_SER = 0; EN = 1;
        tick("t2_up");
        check("t2_const_02", 32'(Q), 32'h02);
        S = 2'b10; SL_SER = 1;
        tick("t2_dn");
        check("t2_const_81", 32'(Q), 32'h81);
        S = 2'b00;
        for (int i = 0; i < 5; i++) tick("t2_hold");
        check("t2_const_hold", 32'(Q), 32'h81);
        EN = 0; SL_SER = 0;

        // 3. burst of 3 shift-up, EN toggling while busy
        load(8'h01, "t3_load");
        S = 2'b01; SR_SER = 0; START = 1; AMT = 4'd3;
        tick("t3_acc");
        check("t3_const_busy", 32'({Q, BUSY}), {23'h0, 8'h02, 1'b1});
        START = 0; S = 2'b11; D = 8'hFF; AMT = 4'd9;
        for (int i = 0; i < 2; i++) begin
            EN = ~EN;
            tick("t3_burst");
        end
        check("t3_const_done", 32'({Q, BUSY, DONE}), {22'h0, 8'h08, 2'b01});
        EN = 0; S = 2'b00;
        tick("t3_after");

        // 4. long shift-down burst aborted by CLR
        load(8'hFF, "t4_load");
        S = 2'b10; SL_SER = 0; START = 1; AMT = 4'd10;
        tick("t4_acc");
        START = 0;
        tick("t4_s2");
        tick("t4_s3");
        check("t4_const_q", 32'(Q), 32'h1F);
        CLR = 1;
        tick("t4_clr");
        CLR = 0;
        for (int i = 0; i < 8; i++) tick("t4_nodone");

        // 5. ignored starts and single-shot burst
        load(8'h3C, "t5_load");
        S = 2'b01; START = 1; AMT = 4'd0; EN = 0;
        tick("t5_amt0");
        S = 2'b00; AMT = 4'd5;
        tick("t5_hold");
        check("t5_const_q", 32'(Q), 32'h3C);
        S = 2'b10; AMT = 4'd1; SL_SER = 1; EN = 1;
        tick("t5_one");
        check("t5_const_one", 32'({Q, BUSY, DONE}), {22'h0, 8'h9E, 2'b01});
        START = 0; EN = 0; S = 2'b00;
        tick("t5_after");

`ifdef SHREG_ROTATE_EN
        // 6. rotating bursts
        load(8'h81, "t6_load");
        ROT = 1; S = 2'b01; START = 1; AMT = 4'd8;
        tick("t6_acc8");
        START = 0;
        for (int i = 0; i < 7; i++) tick("t6_rot8");
        check("t6_const_81", 32'({Q, DONE}), {23'h0, 8'h81, 1'b1});
        START = 1; AMT = 4'd4;
        tick("t6_acc4");
        START = 0;
        for (int i = 0; i < 3; i++) tick("t6_rot4");
        check("t6_const_18", 32'({Q, DONE}), {23'h0, 8'h18, 1'b1});
        ROT = 0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            CLR    = ($urandom_range(0, 49) == 0);
            S      = 2'($urandom_range(0, 3));
            D      = 8'($urandom);
            SR_SER = 1'($urandom);
            SL_SER = 1'($urandom);
            EN     = 1'($urandom);
            START  = ($urandom_range(0, 3) == 0);
            AMT    = 4'($urandom);
`ifdef SHREG_ROTATE_EN
            ROT    = 1'($urandom);
`endif
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
